// File: rtl/ex_muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encodings, default datapath width and counter width.
// Configuration macro: EX_MULDIV_DIV_EN (enables the divide datapath).
// ---------------------------------------------------------------------------
package ex_muldiv_ctrl_pkg;

    localparam int MD_W_DEF = 32;
    // Iteration counter must hold MD_W-1; 6 bits covers widths up to 64.
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIVU = 2'b10,
        MD_REMU = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIVU) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_md_core.sv
// ---------------------------------------------------------------------------
// md_core
// Shift/accumulate datapath for the multiply/divide unit. One bit per step:
// unsigned shift-add multiply (low word) and restoring shift-subtract divide.
// Configuration macro: EX_MULDIV_DIV_EN (without it the divide datapath is
// absent and divide results read as zero).
//
// Ports
//   clk       pipeline clock
//   reset     asynchronous active-low reset
//   load_i    capture operands for op_i
//   step_i    perform one iteration for op_i
//   op_i      operation (latched copy from the controller while running)
//   in_0_i    multiplicand / dividend
//   in_1_i    multiplier / divisor
//   result_o  product low word, quotient or remainder
// ---------------------------------------------------------------------------
module md_core
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int MD_W = MD_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            step_i,
    input  md_op_e          op_i,
    input  logic [MD_W-1:0] in_0_i,
    input  logic [MD_W-1:0] in_1_i,
    output logic [MD_W-1:0] result_o
);

    // a_q: multiplicand (shifted left) or dividend/quotient shift register
    // b_q: multiplier (shifted right) or divisor
    // acc_q: product accumulator or partial remainder
    logic [MD_W-1:0] a_q, a_d;
    logic [MD_W-1:0] b_q, b_d;
    logic [MD_W-1:0] acc_q, acc_d;

`ifdef EX_MULDIV_DIV_EN
    logic [MD_W:0] rem_sh;
    logic [MD_W:0] rem_diff;
    assign rem_sh   = {acc_q, a_q[MD_W-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
`endif

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (load_i) begin
            if (op_i == MD_MUL) begin
                a_d   = in_0_i;
                b_d   = in_1_i;
                acc_d = '0;
            end else begin
`ifdef EX_MULDIV_DIV_EN
                if (in_1_i == '0) begin
                    // Divide by zero resolves at load: quotient all ones,
                    // remainder is the dividend.
                    a_d   = '1;
                    b_d   = '0;
                    acc_d = in_0_i;
                end else begin
                    a_d   = in_0_i;
                    b_d   = in_1_i;
                    acc_d = '0;
                end
`else
                a_d   = '0;
                b_d   = '0;
                acc_d = '0;
`endif
            end
        end else if (step_i) begin
            if (op_i == MD_MUL) begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d = {a_q[MD_W-2:0], 1'b0};
                b_d = {1'b0, b_q[MD_W-1:1]};
            end
`ifdef EX_MULDIV_DIV_EN
            else if (is_div(op_i)) begin
                // Borrow out of the top bit means the trial subtract failed.
                if (!rem_diff[MD_W]) begin
                    acc_d = rem_diff[MD_W-1:0];
                    a_d   = {a_q[MD_W-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[MD_W-1:0];
                    a_d   = {a_q[MD_W-2:0], 1'b0};
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    always_comb begin
        result_o = '0;
        case (op_i)
            MD_MUL:  result_o = acc_q;
`ifdef EX_MULDIV_DIV_EN
            MD_DIVU: result_o = a_q;
            MD_REMU: result_o = acc_q;
`endif
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl
// Iterative multiply/divide unit for the EX stage. Holds the FSM, iteration
// counter and pipeline handshake; the arithmetic lives in md_core.
// Configuration macro: EX_MULDIV_DIV_EN (divide support; when undefined a
// DIVU/REMU completes in one cycle with md_out = 0 and md_exp = 1).
//
//   state | meaning
//   IDLE  | waiting for a start from ID
//   RUN   | one bit per cycle, MD_W cycles
//   DONE  | result presented; held while stall = 1
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   id_en, id_md_op     ID-stage valid and operation
//   id_md_in_0/1        operands
//   stall, flush        pipeline controls; int_detect acts as flush
//   md_busy             combinational stall request
//   md_valid, md_out    result handshake
//   md_exp              divide-by-zero flag
// ---------------------------------------------------------------------------
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int MD_W = MD_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_en,
    input  logic [1:0]      id_md_op,
    input  logic [MD_W-1:0] id_md_in_0,
    input  logic [MD_W-1:0] id_md_in_1,
    input  logic            stall,
    input  logic            flush,
    input  logic            int_detect,
    output logic            md_busy,
    output logic            md_valid,
    output logic [MD_W-1:0] md_out,
    output logic            md_exp
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_W - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    md_op_e           op_q;
    logic             valid_q;
    logic             exp_q;

    md_op_e           id_op;
    logic             start;
    logic             abort;
    logic             fast_done;
    logic             core_load;
    md_op_e           core_op;
    logic [MD_W-1:0]  core_result;

    assign id_op = md_op_e'(id_md_op);
    assign start = id_en & (id_op != MD_NONE) & ~flush & ~int_detect;
    assign abort = flush | int_detect;

    // Operations that finish without iterating: zero divisor, or any divide
    // when the divide datapath is not built.
`ifdef EX_MULDIV_DIV_EN
    assign fast_done = is_div(id_op) && (id_md_in_1 == '0);
`else
    assign fast_done = is_div(id_op);
`endif

    assign core_load = (state_q == ST_IDLE) & start;
    assign core_op   = core_load ? id_op : op_q;

    md_core #(
        .MD_W (MD_W)
    ) u_md_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (core_load),
        .step_i   (state_q == ST_RUN),
        .op_i     (core_op),
        .in_0_i   (id_md_in_0),
        .in_1_i   (id_md_in_1),
        .result_o (core_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            valid_q <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= id_op;
                        cnt_q <= '0;
                        if (fast_done) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                            exp_q   <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            exp_q   <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        exp_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Flush wins over stall.
                    if (abort || !stall) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        exp_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    exp_q   <= 1'b0;
                end
            endcase
        end
    end

    // Gated by reset so no stall request leaks out while held in reset.
    assign md_busy  = reset & (((state_q == ST_IDLE) & start) | (state_q == ST_RUN));
    assign md_valid = valid_q;
    assign md_out   = valid_q ? core_result : '0;
    assign md_exp   = valid_q & exp_q;

endmodule
